// File: rtl/zx_mem_arbiter.sv
// zx_mem_arbiter: 128K/+2/+3 paging registers plus a small FSM that
// time-shares one external SRAM (ROM and RAM) between CPU and video fetch.
module zx_mem_arbiter #(
   parameter int RAM_PAGES_W = 3,   // 3 = 128K, 4 = 256K (bit 3 from 7FFD[6])
   parameter int ROM_PAGES_W = 2,   // 1 = 7FFD[4] only, 2 = {1FFD[2], 7FFD[4]}
   parameter int SRAM_AW     = 19   // must be >= RAM_PAGES_W + 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ioWr,
   input  logic [15:0]        ioA,
   input  logic [7:0]         ioDi,
   input  logic               cpuReq,
   input  logic               cpuWr,
   input  logic [15:0]        cpuA,
   input  logic [7:0]         cpuDi,
   output logic [7:0]         cpuDo,
   output logic               cpuAck,
   input  logic               vidReq,
   input  logic [12:0]        vidA,
   output logic [7:0]         vidDo,
   output logic               vidAck,
   output logic [SRAM_AW-1:0] sramAddr,
   output logic [7:0]         sramDo,
   output logic               sramDoe,
   input  logic [7:0]         sramDi,
   output logic               sramWr
);

   // Page field width inside the SRAM address: bit SRAM_AW-1 splits RAM/ROM.
   localparam int PG_W = SRAM_AW - 15;

   typedef enum logic [2:0] {
      IDLE, VID_A, VID_D, CPU_RA, CPU_RD, WR_S, WR_P, WR_H
   } state_t;

   state_t state, state_d;

   // Paging registers
   logic [3:0] ram_pg;     // 7FFD[2:0], plus 7FFD[6] in 256K builds
   logic       screen;     // 7FFD[3]
   logic       rom_lo;     // 7FFD[4]
   logic       lock;       // 7FFD[5]
   logic [2:0] p1;         // 1FFD[2:0]: special, config / ROM high

   // Latched request operands
   logic        cpu_pend, cpu_wr_q, vid_pend, acc_rom;
   logic [15:0] cpu_a_q;
   logic [7:0]  cpu_di_q;
   logic [12:0] vid_a_q;

   // Combinational address mapping
   logic [1:0]         slot, rom_sel;
   logic [2:0]         sp_pg;
   logic [PG_W-1:0]    cpu_pg;
   logic               cpu_rom;
   logic [SRAM_AW-1:0] cpu_addr, vid_addr;

   logic sel_7ffd, sel_1ffd;
   assign sel_1ffd = ioWr && (ioA[15:12] == 4'b0001) && !ioA[1];
   assign sel_7ffd = ioWr && !ioA[15] && !ioA[1];

   // Bits that only matter in some parameterisations, or not at all.
   logic unused_bits;
   assign unused_bits = ^{ioA[11:2], ioA[0], ram_pg, rom_sel};

   // Paging register writes; 1FFD wins an overlapping decode, lock freezes both.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ram_pg <= '0;
         screen <= 1'b0;
         rom_lo <= 1'b0;
         lock   <= 1'b0;
         p1     <= '0;
      end else if (!lock) begin
         // NOTE: clocked state uses <= so every register samples pre-edge values.
         if (sel_1ffd) begin
            p1 <= ioDi[2:0];
         end else if (sel_7ffd) begin
            ram_pg[2:0] <= ioDi[2:0];
            ram_pg[3]   <= (RAM_PAGES_W > 3) ? ioDi[6] : 1'b0;
            screen      <= ioDi[3];
            rom_lo      <= ioDi[4];
            lock        <= ioDi[5];
         end
      end
   end

   // Pending flags: set by a request when clear, cleared as the ack is issued.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cpu_pend <= 1'b0;
         cpu_wr_q <= 1'b0;
         cpu_a_q  <= '0;
         cpu_di_q <= '0;
         vid_pend <= 1'b0;
         vid_a_q  <= '0;
      end else begin
         if ((state_d == CPU_RD) || (state_d == WR_H)) begin
            cpu_pend <= 1'b0;
         end else if (cpuReq && !cpu_pend) begin
            cpu_pend <= 1'b1;
            cpu_wr_q <= cpuWr;
            cpu_a_q  <= cpuA;
            cpu_di_q <= cpuDi;
         end
         if (state_d == VID_D) begin
            vid_pend <= 1'b0;
         end else if (vidReq && !vid_pend) begin
            vid_pend <= 1'b1;
            vid_a_q  <= vidA;
         end
      end
   end

   // Map the latched CPU address and the video offset onto SRAM addresses.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      cpu_rom = 1'b0;
      cpu_pg  = '0;
      sp_pg   = 3'd0;
      slot    = cpu_a_q[15:14];
      rom_sel = {p1[2], rom_lo};
      if (p1[0]) begin
         case (p1[2:1])
            2'd0:    sp_pg = {1'b0, slot};
            2'd1:    sp_pg = {1'b1, slot};
            2'd2:    sp_pg = (slot == 2'd3) ? 3'd3 : {1'b1, slot};
            default: begin
               case (slot)
                  2'd0:    sp_pg = 3'd4;
                  2'd1:    sp_pg = 3'd7;
                  2'd2:    sp_pg = 3'd6;
                  default: sp_pg = 3'd3;
               endcase
            end
         endcase
         cpu_pg = PG_W'(sp_pg);
      end else begin
         case (slot)
            2'd0: begin
               cpu_rom = 1'b1;
               cpu_pg  = PG_W'(rom_sel[ROM_PAGES_W-1:0]);
            end
            2'd1:    cpu_pg = PG_W'(3'd5);
            2'd2:    cpu_pg = PG_W'(3'd2);
            default: cpu_pg = PG_W'(ram_pg[RAM_PAGES_W-1:0]);
         endcase
      end
      cpu_addr = {cpu_rom, cpu_pg, cpu_a_q[13:0]};
      vid_addr = {1'b0, PG_W'(screen ? 3'd7 : 3'd5), 1'b0, vid_a_q};
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Next state: video beats CPU in IDLE; every access returns to IDLE.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (vid_pend)      state_d = VID_A;
            else if (cpu_pend) state_d = cpu_wr_q ? WR_S : CPU_RA;
         end
         VID_A:   state_d = VID_D;
         CPU_RA:  state_d = CPU_RD;
         WR_S:    state_d = WR_P;
         WR_P:    state_d = WR_H;
         default: state_d = IDLE;   // VID_D, CPU_RD, WR_H
      endcase
   end

   // Registered SRAM and handshake outputs, decoded from the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sramAddr <= '0;
         sramDo   <= '0;
         sramDoe  <= 1'b0;
         sramWr   <= 1'b1;
         cpuDo    <= '0;
         vidDo    <= '0;
         cpuAck   <= 1'b0;
         vidAck   <= 1'b0;
         acc_rom  <= 1'b0;
      end else begin
         cpuAck  <= (state_d == CPU_RD) || (state_d == WR_H);
         vidAck  <= (state_d == VID_D);
         sramDoe <= (state_d inside {WR_S, WR_P, WR_H});
         sramWr  <= !((state_d == WR_P) && !acc_rom);
         if ((state == IDLE) && (state_d == VID_A)) begin
            sramAddr <= vid_addr;
         end
         if ((state == IDLE) && ((state_d == CPU_RA) || (state_d == WR_S))) begin
            sramAddr <= cpu_addr;
            acc_rom  <= cpu_rom;
            if (state_d == WR_S) sramDo <= cpu_di_q;
         end
         if (state_d == CPU_RD) cpuDo <= sramDi;
         if (state_d == VID_D)  vidDo <= sramDi;
      end
   end

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Directed bench for zx_mem_arbiter: a 128K build and a 256K build share
// stimulus; the SRAM read data is a fixed function of the address.
module tb_zx_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ioWr = 1'b0;
   logic [15:0] ioA = '0;
   logic [7:0]  ioDi = '0;
   logic        cpuReq = 1'b0, cpuWr = 1'b0;
   logic [15:0] cpuA = '0;
   logic [7:0]  cpuDi = '0;
   logic        vidReq = 1'b0;
   logic [12:0] vidA = '0;

   logic [7:0]  cpuDo, vidDo, sramDo, sramDi;
   logic        cpuAck, vidAck, sramDoe, sramWr;
   logic [18:0] sramAddr;

   logic [7:0]  cpuDo4, vidDo4, sramDo4, sramDi4;
   logic        cpuAck4, vidAck4, sramDoe4, sramWr4;
   logic [18:0] sramAddr4;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   function automatic logic [7:0] model_byte(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
   endfunction

   assign sramDi  = model_byte(sramAddr);
   assign sramDi4 = model_byte(sramAddr4);

   zx_mem_arbiter #(.RAM_PAGES_W(3), .ROM_PAGES_W(2), .SRAM_AW(19)) dut (
      .clock(clock), .reset(reset), .ioWr(ioWr), .ioA(ioA), .ioDi(ioDi),
      .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA), .cpuDi(cpuDi),
      .cpuDo(cpuDo), .cpuAck(cpuAck), .vidReq(vidReq), .vidA(vidA),
      .vidDo(vidDo), .vidAck(vidAck), .sramAddr(sramAddr), .sramDo(sramDo),
      .sramDoe(sramDoe), .sramDi(sramDi), .sramWr(sramWr));

   zx_mem_arbiter #(.RAM_PAGES_W(4), .ROM_PAGES_W(2), .SRAM_AW(19)) dut4 (
      .clock(clock), .reset(reset), .ioWr(ioWr), .ioA(ioA), .ioDi(ioDi),
      .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA), .cpuDi(cpuDi),
      .cpuDo(cpuDo4), .cpuAck(cpuAck4), .vidReq(vidReq), .vidA(vidA),
      .vidDo(vidDo4), .vidAck(vidAck4), .sramAddr(sramAddr4), .sramDo(sramDo4),
      .sramDoe(sramDoe4), .sramDi(sramDi4), .sramWr(sramWr4));

   task automatic io_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock);
      ioWr = 1'b1; ioA = a; ioDi = d;
      @(negedge clock);
      ioWr = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      @(negedge clock); reset = 1'b0;
   endtask

   // One CPU access; cycle 1 is the cycle after the request pulse.
   task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                             output int ack_cyc, output logic [18:0] addr,
                             output logic [18:0] addr4, output logic [7:0] rdata,
                             output logic [7:0] wdata, output int wr_low,
                             output logic doe_after);
      ack_cyc = -1; addr = 'x; addr4 = 'x; rdata = 'x; wdata = 'x;
      wr_low = 0; doe_after = 1'bx;
      @(negedge clock);
      cpuReq = 1'b1; cpuWr = wr; cpuA = a; cpuDi = d;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (n == 1) cpuReq = 1'b0;
         if (sramWr === 1'b0) wr_low++;
         if (ack_cyc >= 0) begin
            doe_after = sramDoe;
            break;
         end
         if (cpuAck === 1'b1) begin
            ack_cyc = n; addr = sramAddr; addr4 = sramAddr4;
            rdata = cpuDo; wdata = sramDo;
         end
      end
   endtask

   task automatic vid_access(input logic [12:0] va, output int ack_cyc,
                             output logic [18:0] addr, output logic [7:0] data);
      ack_cyc = -1; addr = 'x; data = 'x;
      @(negedge clock);
      vidReq = 1'b1; vidA = va;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (n == 1) vidReq = 1'b0;
         if (vidAck === 1'b1) begin
            ack_cyc = n; addr = sramAddr; data = vidDo;
            break;
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clock); @(negedge clock);
      checks++; if (sramWr !== 1'b1) begin errors++; $display("FAIL reset sramWr: got %b want 1", sramWr); end
      checks++; if (sramDoe !== 1'b0) begin errors++; $display("FAIL reset sramDoe: got %b want 0", sramDoe); end
      checks++; if (sramAddr !== 19'h0) begin errors++; $display("FAIL reset sramAddr: got %h want 0", sramAddr); end
      checks++; if (sramDo !== 8'h0) begin errors++; $display("FAIL reset sramDo: got %h want 0", sramDo); end
      checks++; if ({cpuDo, vidDo} !== 16'h0) begin errors++; $display("FAIL reset data: got %h/%h want 0/0", cpuDo, vidDo); end
      checks++; if ({cpuAck, vidAck} !== 2'b00) begin errors++; $display("FAIL reset acks: got %b%b want 00", cpuAck, vidAck); end
      reset = 1'b0;
   endtask

   task automatic test_rom_read();
      int ack, wl; logic [18:0] ad, ad4; logic [7:0] rd, wd; logic doe;
      cpu_access(1'b0, 16'h0000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ack !== 3) begin errors++; $display("FAIL rom_read ack cycle: got %0d want 3", ack); end
      checks++; if (ad !== 19'h40000) begin errors++; $display("FAIL rom_read addr: got %h want 40000", ad); end
      checks++; if (rd !== model_byte(19'h40000)) begin errors++; $display("FAIL rom_read data: got %h want %h", rd, model_byte(19'h40000)); end
   endtask

   task automatic test_write_map();
      int ack, wl; logic [18:0] ad, ad4; logic [7:0] rd, wd; logic doe;
      io_write(16'h7FFD, 8'h13);
      cpu_access(1'b1, 16'hC000, 8'hA5, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h0C000) begin errors++; $display("FAIL wr_c000 addr: got %h want 0c000", ad); end
      checks++; if (ack !== 4) begin errors++; $display("FAIL wr_c000 ack cycle: got %0d want 4", ack); end
      checks++; if (wl !== 1) begin errors++; $display("FAIL wr_c000 sramWr low cycles: got %0d want 1", wl); end
      checks++; if (wd !== 8'hA5) begin errors++; $display("FAIL wr_c000 sramDo: got %h want a5", wd); end
      checks++; if (doe !== 1'b0) begin errors++; $display("FAIL wr_c000 sramDoe after ack: got %b want 0", doe); end
      cpu_access(1'b1, 16'h4000, 8'h3C, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h14000) begin errors++; $display("FAIL wr_4000 addr: got %h want 14000", ad); end
      cpu_access(1'b0, 16'h0001, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h44001) begin errors++; $display("FAIL rom1_read addr: got %h want 44001", ad); end
      cpu_access(1'b1, 16'h0010, 8'h77, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (wl !== 0) begin errors++; $display("FAIL rom_write sramWr low cycles: got %0d want 0", wl); end
      checks++; if (ack !== 4) begin errors++; $display("FAIL rom_write ack cycle: got %0d want 4", ack); end
   endtask

   task automatic test_lock();
      int ack, wl; logic [18:0] ad, ad4; logic [7:0] rd, wd; logic doe;
      io_write(16'h7FFD, 8'h20);
      io_write(16'h7FFD, 8'h07);
      io_write(16'h1FFD, 8'h01);
      cpu_access(1'b0, 16'hC000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h00000) begin errors++; $display("FAIL lock c000 addr: got %h want 00000", ad); end
      cpu_access(1'b0, 16'h2000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h42000) begin errors++; $display("FAIL lock rom addr: got %h want 42000", ad); end
      apply_reset();
   endtask

   task automatic test_special();
      int ack, wl; logic [18:0] ad, ad4; logic [7:0] rd, wd; logic doe;
      logic [15:0] va [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
      logic [18:0] ea [4] = '{19'h10123, 19'h1C567, 19'h189AB, 19'h0CDEF};
      io_write(16'h1FFD, 8'h04);
      io_write(16'h7FFD, 8'h10);
      cpu_access(1'b0, 16'h0005, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h4C005) begin errors++; $display("FAIL rom3 addr: got %h want 4c005", ad); end
      io_write(16'h1FFD, 8'h07);
      for (int i = 0; i < 4; i++) begin
         cpu_access(1'b0, va[i], 8'h00, ack, ad, ad4, rd, wd, wl, doe);
         checks++; if (ad !== ea[i]) begin errors++; $display("FAIL cfg3 slot%0d addr: got %h want %h", i, ad, ea[i]); end
      end
      cpu_access(1'b1, 16'h0000, 8'h11, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (wl !== 1 || ad !== 19'h10000) begin errors++; $display("FAIL cfg3 write slot0: got wrlow=%0d addr=%h want 1/10000", wl, ad); end
      io_write(16'h1FFD, 8'h03);
      cpu_access(1'b0, 16'hC000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h1C000) begin errors++; $display("FAIL cfg1 c000 addr: got %h want 1c000", ad); end
      io_write(16'h1FFD, 8'h05);
      cpu_access(1'b0, 16'h4000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h14000) begin errors++; $display("FAIL cfg2 4000 addr: got %h want 14000", ad); end
      cpu_access(1'b0, 16'hC000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad !== 19'h0C000) begin errors++; $display("FAIL cfg2 c000 addr: got %h want 0c000", ad); end
      io_write(16'h1FFD, 8'h00);
   endtask

   task automatic test_video_priority();
      int vack, cack, ack; logic [18:0] vaddr, caddr, ad; logic [7:0] vdata, cdata, d;
      vack = -1; cack = -1; vaddr = 'x; caddr = 'x; vdata = 'x; cdata = 'x;
      io_write(16'h7FFD, 8'h08);
      @(negedge clock);
      vidReq = 1'b1; vidA = 13'h1ABC;
      cpuReq = 1'b1; cpuWr = 1'b0; cpuA = 16'h8000;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (n == 1) begin vidReq = 1'b0; cpuReq = 1'b0; end
         if (vidAck === 1'b1 && vack < 0) begin vack = n; vaddr = sramAddr; vdata = vidDo; end
         if (cpuAck === 1'b1 && cack < 0) begin cack = n; caddr = sramAddr; cdata = cpuDo; break; end
      end
      checks++; if (vack !== 3) begin errors++; $display("FAIL prio vidAck cycle: got %0d want 3", vack); end
      checks++; if (vaddr !== 19'h1DABC) begin errors++; $display("FAIL prio vid addr: got %h want 1dabc", vaddr); end
      checks++; if (vdata !== model_byte(19'h1DABC)) begin errors++; $display("FAIL prio vid data: got %h want %h", vdata, model_byte(19'h1DABC)); end
      checks++; if (cack !== 6) begin errors++; $display("FAIL prio cpuAck cycle: got %0d want 6", cack); end
      checks++; if (caddr !== 19'h08000 || cdata !== model_byte(19'h08000)) begin errors++; $display("FAIL prio cpu read: got %h/%h want 08000/%h", caddr, cdata, model_byte(19'h08000)); end
      io_write(16'h7FFD, 8'h00);
      vid_access(13'h1FFF, ack, ad, d);
      checks++; if (ack !== 3 || ad !== 19'h15FFF) begin errors++; $display("FAIL vid screen0: got ack=%0d addr=%h want 3/15fff", ack, ad); end
      checks++; if (d !== model_byte(19'h15FFF)) begin errors++; $display("FAIL vid screen0 data: got %h want %h", d, model_byte(19'h15FFF)); end
   endtask

   task automatic test_back_to_back();
      int cack, vack, ccount, vcount;
      cack = -1; vack = -1; ccount = 0; vcount = 0;
      @(negedge clock);
      cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 16'h8000; cpuDi = 8'h42;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clock);
         if (n == 1) begin
            cpuReq = 1'b1; cpuWr = 1'b0; cpuA = 16'h4000;   // ignored: still pending
            vidReq = 1'b1; vidA = 13'h0000;
         end
         if (n == 2) begin cpuReq = 1'b0; vidReq = 1'b0; end
         if (cpuAck === 1'b1) begin ccount++; if (cack < 0) cack = n; end
         if (vidAck === 1'b1) begin vcount++; if (vack < 0) vack = n; end
      end
      checks++; if (cack !== 4) begin errors++; $display("FAIL b2b write ack cycle: got %0d want 4", cack); end
      checks++; if (vack !== 7) begin errors++; $display("FAIL b2b vidAck cycle: got %0d want 7", vack); end
      checks++; if (ccount !== 1) begin errors++; $display("FAIL b2b cpu ack count: got %0d want 1", ccount); end
      checks++; if (vcount !== 1) begin errors++; $display("FAIL b2b vid ack count: got %0d want 1", vcount); end
   endtask

   task automatic test_reset_mid_write();
      int ack, wl, acks; logic [18:0] ad, ad4; logic [7:0] rd, wd; logic doe;
      acks = 0;
      @(negedge clock);
      cpuReq = 1'b1; cpuWr = 1'b1; cpuA = 16'hC000; cpuDi = 8'hEE;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clock);
         if (n == 1) cpuReq = 1'b0;
      end
      checks++; if (sramWr !== 1'b0 || sramDoe !== 1'b1) begin errors++; $display("FAIL mid_write WR_P: got wr=%b doe=%b want 0/1", sramWr, sramDoe); end
      #2 reset = 1'b1;
      #1;
      checks++; if (sramWr !== 1'b1 || sramDoe !== 1'b0) begin errors++; $display("FAIL async reset: got wr=%b doe=%b want 1/0", sramWr, sramDoe); end
      for (int n = 0; n < 3; n++) begin
         @(negedge clock);
         if (cpuAck === 1'b1) acks++;
      end
      reset = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clock);
         if (cpuAck === 1'b1) acks++;
      end
      checks++; if (acks !== 0) begin errors++; $display("FAIL aborted write acks: got %0d want 0", acks); end
      cpu_access(1'b0, 16'h4000, 8'h00, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ack !== 3 || ad !== 19'h14000) begin errors++; $display("FAIL post-reset read: got ack=%0d addr=%h want 3/14000", ack, ad); end
   endtask

   task automatic test_256k();
      int ack, wl; logic [18:0] ad, ad4; logic [7:0] rd, wd; logic doe;
      io_write(16'h7FFD, 8'h41);
      cpu_access(1'b1, 16'hC000, 8'h5C, ack, ad, ad4, rd, wd, wl, doe);
      checks++; if (ad4 !== 19'h24000) begin errors++; $display("FAIL 256k addr: got %h want 24000", ad4); end
      checks++; if (ad !== 19'h04000) begin errors++; $display("FAIL 128k bit6 ignored: got %h want 04000", ad); end
   endtask

   initial begin
      test_reset();
      test_rom_read();
      test_write_map();
      test_lock();
      test_special();
      test_video_priority();
      test_back_to_back();
      test_reset_mid_write();
      test_256k();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
